lane_distributor: RTL and testbench
===================================

LANE_DISTRIBUTOR -- requirements
Module: lane_distributor

Interface
REQ-001 SHALL provide parameter NB_DATA_TAGGED, default 67: width of one tagged block, alignment tag included.
REQ-002 SHALL provide parameter N_LANES, default 20: maximum number of PCS lanes.
REQ-003 SHALL provide parameter NB_LANE_SEL, default 5: lane pointer and lane count width, at least clog2(N_LANES+1).
REQ-004 SHALL provide port i_clock  in  1: single clock; all state on rising edge.
REQ-005 SHALL provide port i_reset  in  1: asynchronous, active-high reset.
REQ-006 SHALL provide port i_enable  in  1: block enable; low freezes all state.
REQ-007 SHALL provide port i_valid  in  1: fast-rate block strobe; i_data accepted when high.
REQ-008 SHALL provide port i_data  in  NB_DATA_TAGGED: incoming scrambled block.
REQ-009 SHALL provide port i_set_shadow  in  1: slow-rate strobe; transfers the working buffer to the output.
REQ-010 SHALL provide port i_rf_active_lanes  in  NB_LANE_SEL: requested active lane count, 1..N_LANES.
REQ-011 SHALL provide port o_data  out  NB_DATA_TAGGED*N_LANES: lane bus; lane k at bits [(N_LANES-k)*NB_DATA_TAGGED-1 -: NB_DATA_TAGGED], lane 0 at the MSBs.
REQ-012 SHALL provide port o_valid  out  1: one-cycle pulse when o_data updates.
REQ-013 SHALL provide port o_lane_ptr  out  NB_LANE_SEL: next working-buffer slot to be written.
REQ-014 SHALL provide port o_fill_error  out  1: one-cycle pulse, coincident with o_valid, for an incomplete fill.

Function
REQ-015 SHALL, on i_enable=1 and i_valid=1, write i_data into working slot lane_ptr and advance lane_ptr.
REQ-016 SHALL wrap lane_ptr from active_lanes-1 to 0, where active_lanes is the latched count.
REQ-017 SHALL latch active_lanes from i_rf_active_lanes only on an accepted i_set_shadow; values 0 or >N_LANES latch as N_LANES.
REQ-018 SHALL, on i_enable=1 and i_set_shadow=1, load shadow lanes 0..active_lanes-1 from the working buffer, including any word written that same cycle.
REQ-019 SHALL force shadow lanes >= active_lanes to zero; the currently latched (pre-update) active_lanes governs this transfer.
REQ-020 SHALL drive o_data directly from the shadow register, so o_data and o_valid=1 appear one cycle after i_set_shadow.
REQ-021 SHALL, on each accepted i_set_shadow, force lane_ptr to 0; a same-cycle i_valid write completes first.
REQ-022 SHALL assert o_fill_error with o_valid when lane_ptr, after any same-cycle write and wrap, is nonzero.
REQ-023 SHALL leave unwritten working slots holding their previous contents; no clear on transfer.
REQ-024 SHALL, with i_enable=0, hold working, shadow, lane_ptr and active_lanes, and drive o_valid=0 and o_fill_error=0.
REQ-025 SHALL permit i_valid and i_set_shadow to arrive at any cycle spacing without internal assumption of ratio.

Reset
REQ-026 SHALL on i_reset=1 immediately clear working and shadow to zero, lane_ptr=0, o_valid=0, o_fill_error=0, active_lanes=N_LANES.
REQ-027 SHALL resume normal operation on the first rising edge after i_reset deasserts, with the first block written to lane 0.

Verification
REQ-028 SHALL cover full fill: 20 valids with data=k, set_shadow with 20th -> next cycle o_valid=1, lane k=k, o_fill_error=0, o_lane_ptr=0.
REQ-029 SHALL cover early shadow: 7 valids then set_shadow -> o_valid=1, o_fill_error=1, lanes 0..6 new, lanes 7..19 prior working contents, o_lane_ptr=0.
REQ-030 SHALL cover reduced lanes: active=4 latched by a set_shadow, then 8 valids (wrap 3->0 twice) plus set_shadow -> lanes 0..3 = words 4..7, lanes 4..19 = 0, o_fill_error=0.
REQ-031 SHALL cover illegal count: i_rf_active_lanes=0 latched -> behaves as 20; ptr wraps at 19.
REQ-032 SHALL cover enable gating: i_enable=0 for 5 cycles at ptr=9 with valids and set_shadow toggling -> ptr stays 9, o_valid=0, o_data unchanged.
REQ-033 SHALL cover async reset mid-fill: i_reset pulsed between edges at ptr=11 -> o_data=0, o_lane_ptr=0 without a clock edge; next valid lands in lane 0.

Source files
------------

// File: rtl/lane_distributor.sv
// Round-robin distributor of tagged blocks onto a PCS lane bus.
// A working buffer fills at block rate; a shadow copy drives the lanes.
module lane_distributor #(
    parameter int NB_DATA_TAGGED = 67,
    parameter int N_LANES        = 20,
    parameter int NB_LANE_SEL    = 5
) (
    input  logic                              i_clock,
    input  logic                              i_reset,
    input  logic                              i_enable,
    input  logic                              i_valid,
    input  logic [NB_DATA_TAGGED-1:0]         i_data,
    input  logic                              i_set_shadow,
    input  logic [NB_LANE_SEL-1:0]            i_rf_active_lanes,
    output logic [NB_DATA_TAGGED*N_LANES-1:0] o_data,
    output logic                              o_valid,
    output logic [NB_LANE_SEL-1:0]            o_lane_ptr,
    output logic                              o_fill_error
);

    localparam logic [NB_LANE_SEL-1:0] MAX_LANES = NB_LANE_SEL'(N_LANES);

    logic [NB_DATA_TAGGED-1:0] working [N_LANES];
    logic [NB_DATA_TAGGED-1:0] shadow  [N_LANES];
    logic [NB_LANE_SEL-1:0]    lane_ptr;
    logic [NB_LANE_SEL-1:0]    active_lanes;
    logic [NB_LANE_SEL-1:0]    ptr_next;
    logic [NB_LANE_SEL-1:0]    active_req;
    logic                      write_en;
    logic                      transfer;

    always_comb begin
        write_en = i_enable & i_valid;
        transfer = i_enable & i_set_shadow;
        ptr_next = lane_ptr;
        if (write_en) begin
            if (lane_ptr == active_lanes - 1'b1)
                ptr_next = '0;
            else
                ptr_next = lane_ptr + 1'b1;
        end
        // Out-of-range lane counts fall back to the full lane set
        if (i_rf_active_lanes == '0 || i_rf_active_lanes > MAX_LANES)
            active_req = MAX_LANES;
        else
            active_req = i_rf_active_lanes;
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            for (int k = 0; k < N_LANES; k++) begin
                working[k] <= '0;
                shadow[k]  <= '0;
            end
            lane_ptr     <= '0;
            active_lanes <= MAX_LANES;
            o_valid      <= 1'b0;
            o_fill_error <= 1'b0;
        end else if (!i_enable) begin
            o_valid      <= 1'b0;
            o_fill_error <= 1'b0;
        end else begin
            o_valid      <= i_set_shadow;
            o_fill_error <= i_set_shadow && (ptr_next != '0);
            for (int k = 0; k < N_LANES; k++) begin
                if (write_en && lane_ptr == NB_LANE_SEL'(k))
                    working[k] <= i_data;
            end
            if (transfer) begin
                // Old lane count governs this copy; new count applies next
                for (int k = 0; k < N_LANES; k++) begin
                    if (NB_LANE_SEL'(k) >= active_lanes)
                        shadow[k] <= '0;
                    else if (write_en && lane_ptr == NB_LANE_SEL'(k))
                        shadow[k] <= i_data;
                    else
                        shadow[k] <= working[k];
                end
                lane_ptr     <= '0;
                active_lanes <= active_req;
            end else begin
                lane_ptr <= ptr_next;
            end
        end
    end

    for (genvar g = 0; g < N_LANES; g++) begin : g_lane
        assign o_data[(N_LANES-g)*NB_DATA_TAGGED-1 -: NB_DATA_TAGGED] = shadow[g];
    end

    assign o_lane_ptr = lane_ptr;

endmodule

// File: tb/tb_lane_distributor.sv
// Bench for lane_distributor: directed scenarios plus random traffic,
// all compared against a lane-array reference model.
module tb_lane_distributor;

    localparam int W  = 67;
    localparam int N  = 20;
    localparam int SW = 5;

    logic             i_clock = 1'b0;
    logic             i_reset;
    logic             i_enable;
    logic             i_valid;
    logic [W-1:0]     i_data;
    logic             i_set_shadow;
    logic [SW-1:0]    i_rf_active_lanes;
    logic [W*N-1:0]   o_data;
    logic             o_valid;
    logic [SW-1:0]    o_lane_ptr;
    logic             o_fill_error;

    lane_distributor #(
        .NB_DATA_TAGGED(W),
        .N_LANES(N),
        .NB_LANE_SEL(SW)
    ) dut (
        .i_clock(i_clock),
        .i_reset(i_reset),
        .i_enable(i_enable),
        .i_valid(i_valid),
        .i_data(i_data),
        .i_set_shadow(i_set_shadow),
        .i_rf_active_lanes(i_rf_active_lanes),
        .o_data(o_data),
        .o_valid(o_valid),
        .o_lane_ptr(o_lane_ptr),
        .o_fill_error(o_fill_error)
    );

    always #5 i_clock = ~i_clock;

    int n_checks = 0;
    int n_pass   = 0;

    logic [W-1:0] m_work [N];
    logic [W-1:0] m_shad [N];
    int           m_ptr;
    int           m_active;
    bit           m_valid;
    bit           m_ferr;

    task automatic check(input string tag, input logic [W*N-1:0] got,
                         input logic [W*N-1:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [W-1:0] lane(input int k);
        return o_data[(N-k)*W-1 -: W];
    endfunction

    function automatic logic [W*N-1:0] model_bus();
        logic [W*N-1:0] b;
        for (int k = 0; k < N; k++)
            b[(N-k)*W-1 -: W] = m_shad[k];
        return b;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_work[k] = '0;
            m_shad[k] = '0;
        end
        m_ptr    = 0;
        m_active = N;
        m_valid  = 0;
        m_ferr   = 0;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".valid"}, W*N'(o_valid), W*N'(m_valid));
        check({tag, ".ferr"}, W*N'(o_fill_error), W*N'(m_ferr));
        check({tag, ".ptr"}, W*N'(o_lane_ptr), W*N'(m_ptr));
        check({tag, ".data"}, o_data, model_bus());
    endtask

    // One clock: drive, advance model from the lane-array view, compare.
    task automatic cycle(input bit en, input bit v, input bit ss,
                         input logic [W-1:0] d, input int rf,
                         input string tag);
        i_enable          = en;
        i_valid           = v;
        i_set_shadow      = ss;
        i_data            = d;
        i_rf_active_lanes = SW'(rf);
        @(posedge i_clock);
        m_valid = 0;
        m_ferr  = 0;
        if (en) begin
            if (v) begin
                m_work[m_ptr] = d;
                m_ptr = (m_ptr + 1) % m_active;
            end
            if (ss) begin
                for (int k = 0; k < N; k++)
                    m_shad[k] = (k < m_active) ? m_work[k] : '0;
                m_valid  = 1;
                m_ferr   = (m_ptr != 0);
                m_ptr    = 0;
                m_active = (rf == 0 || rf > N) ? N : rf;
            end
        end
        #1;
        compare_all(tag);
    endtask

    function automatic logic [W-1:0] rnd_word();
        return {$urandom, $urandom, $urandom};
    endfunction

    logic [W-1:0] saved;

    initial begin
        i_reset = 1'b1;
        i_enable = 0;
        i_valid = 0;
        i_set_shadow = 0;
        i_data = '0;
        i_rf_active_lanes = '0;
        model_reset();
        repeat (2) @(posedge i_clock);
        #1;
        compare_all("reset");
        @(negedge i_clock);
        i_reset = 1'b0;

        // Full fill, shadow with the 20th word
        for (int k = 0; k < N; k++)
            cycle(1, 1, k == N - 1, W'(k), N, "full");
        check("full.lane0", W*N'(lane(0)), W*N'(0));
        check("full.lane7", W*N'(lane(7)), W*N'(7));
        check("full.lane19", W*N'(lane(19)), W*N'(19));
        check("full.ferr0", W*N'(o_fill_error), '0);

        // Early shadow after 7 words
        for (int k = 0; k < 7; k++)
            cycle(1, 1, 0, W'(100 + k), N, "early");
        cycle(1, 0, 1, '0, N, "early.ss");
        check("early.ferr1", W*N'(o_fill_error), W*N'(1));
        check("early.lane6", W*N'(lane(6)), W*N'(106));
        check("early.lane7", W*N'(lane(7)), W*N'(7));

        // Reduced lane count of 4
        cycle(1, 0, 1, '0, 4, "red.latch");
        for (int j = 0; j < 8; j++)
            cycle(1, 1, j == 7, W'(200 + j), 4, "red");
        check("red.lane0", W*N'(lane(0)), W*N'(204));
        check("red.lane3", W*N'(lane(3)), W*N'(207));
        check("red.lane4", W*N'(lane(4)), W*N'(0));
        check("red.ferr", W*N'(o_fill_error), W*N'(0));

        // Illegal count 0 behaves as full width
        cycle(1, 0, 1, '0, 0, "ill.latch");
        cycle(1, 0, 1, '0, 0, "ill.apply");
        for (int k = 0; k < N - 1; k++)
            cycle(1, 1, 0, W'(300 + k), 0, "ill");
        check("ill.ptr19", W*N'(o_lane_ptr), W*N'(19));
        cycle(1, 1, 0, W'(319), 0, "ill.wrap");
        check("ill.ptr0", W*N'(o_lane_ptr), W*N'(0));

        // Enable gating at ptr 9
        for (int k = 0; k < 9; k++)
            cycle(1, 1, 0, W'(400 + k), N, "gate.fill");
        saved = lane(0);
        for (int c = 0; c < 5; c++)
            cycle(0, c[0], ~c[0], rnd_word(), 3, "gate");
        check("gate.ptr9", W*N'(o_lane_ptr), W*N'(9));
        check("gate.lane0", W*N'(lane(0)), W*N'(saved));

        // Async reset mid-fill at ptr 11
        cycle(1, 1, 0, W'(409), N, "ar.fill");
        cycle(1, 1, 0, W'(410), N, "ar.fill");
        check("ar.ptr11", W*N'(o_lane_ptr), W*N'(11));
        @(negedge i_clock);
        i_reset = 1'b1;
        #2;
        model_reset();
        check("ar.data0", o_data, '0);
        check("ar.ptr0", W*N'(o_lane_ptr), '0);
        i_reset = 1'b0;
        cycle(1, 1, 0, W'(555), N, "ar.post");
        cycle(1, 0, 1, '0, N, "ar.ss");
        check("ar.lane0", W*N'(lane(0)), W*N'(555));

        // Random traffic
        for (int c = 0; c < 600; c++)
            cycle($urandom_range(0, 9) != 0,
                  $urandom_range(0, 9) < 7,
                  $urandom_range(0, 9) == 0,
                  rnd_word(), int'($urandom_range(0, 31)), "rnd");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
